// File: rtl/line_buf_ring_if.sv
// Video stream bundle for the line buffer ring: raw timing and pixel in,
// delayed timing plus vertical taps out.
interface line_buf_ring_if #(
  parameter int DW     = 30,
  parameter int HACT   = 10,
  parameter int NLINES = 3
);
  localparam int AW = $clog2(HACT);

  logic                 i_vsync;
  logic                 i_hsync;
  logic                 i_de;
  logic [DW-1:0]        i_data;
  logic                 o_vsync;
  logic                 o_hsync;
  logic                 o_de;
  logic [NLINES*DW-1:0] o_taps;
  logic [NLINES-1:0]    o_tap_vld;
  logic [AW-1:0]        o_col;
  logic                 o_ovf;

  modport master (
    output i_vsync, i_hsync, i_de, i_data,
    input  o_vsync, o_hsync, o_de, o_taps, o_tap_vld, o_col, o_ovf
  );

  modport slave (
    input  i_vsync, i_hsync, i_de, i_data,
    output o_vsync, o_hsync, o_de, o_taps, o_tap_vld, o_col, o_ovf
  );
endinterface

// File: rtl/line_buf_ring.sv
// Ring of NLINES-1 line memories presenting NLINES vertically aligned pixels
// (current line plus the lines above it) with a one-clock pipeline.
module line_buf_ring #(
  parameter int DW     = 30,
  parameter int HACT   = 10,
  parameter int NLINES = 3
) (
  input  logic          clk,
  input  logic          rst,
  line_buf_ring_if.slave bus
);
  localparam int M  = NLINES - 1;
  localparam int AW = $clog2(HACT);
  localparam int CW = $clog2(HACT + 1);
  localparam int PW = (M > 1) ? $clog2(M) : 1;
  localparam int FW = $clog2(M + 1);

  logic [CW-1:0]     col_reg, col_next;
  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [FW-1:0]     fill_reg, fill_next;
  logic              ovf_reg, ovf_next;
  logic              de_reg;

  logic              vs_out_reg, hs_out_reg, de_out_reg;
  logic [DW-1:0]     tap0_reg;
  logic [PW-1:0]     ptr_out_reg;
  logic [NLINES-1:0] vld_reg, vld_next;
  logic [AW-1:0]     col_out_reg;

  logic              in_line, eol, wr_en;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     rd_bus [M];

  assign in_line = (col_reg < CW'(HACT));
  assign eol     = de_reg & ~bus.i_de;
  // Writes stop once the line overflows, during vsync and during reset.
  assign wr_en   = bus.i_de & in_line & ~bus.i_vsync & ~rst;
  assign addr    = in_line ? col_reg[AW-1:0] : '0;

  always_comb begin
    col_next    = col_reg;
    wr_ptr_next = wr_ptr_reg;
    fill_next   = fill_reg;
    ovf_next    = ovf_reg;
    if (bus.i_vsync) begin
      col_next    = '0;
      wr_ptr_next = '0;
      fill_next   = '0;
      ovf_next    = 1'b0;
    end else begin
      if (eol) begin
        col_next    = '0;
        wr_ptr_next = (wr_ptr_reg == PW'(M - 1)) ? '0 : wr_ptr_reg + 1'b1;
        if (fill_reg != FW'(M))
          fill_next = fill_reg + 1'b1;
      end else if (bus.i_de && in_line) begin
        col_next = col_reg + 1'b1;
      end
      if (bus.i_de && !in_line)
        ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg    <= '0;
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      ovf_reg    <= 1'b0;
      de_reg     <= 1'b0;
    end else begin
      col_reg    <= col_next;
      wr_ptr_reg <= wr_ptr_next;
      fill_reg   <= fill_next;
      ovf_reg    <= ovf_next;
      de_reg     <= bus.i_de;
    end
  end

  // Tap k is valid when k complete lines are buffered and the column is in range.
  always_comb begin
    vld_next    = '0;
    vld_next[0] = bus.i_de;
    for (int k = 1; k < NLINES; k++)
      vld_next[k] = bus.i_de & (fill_reg >= FW'(k)) & in_line;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_out_reg  <= 1'b0;
      hs_out_reg  <= 1'b0;
      de_out_reg  <= 1'b0;
      tap0_reg    <= '0;
      ptr_out_reg <= '0;
      vld_reg     <= '0;
      col_out_reg <= '0;
    end else begin
      vs_out_reg  <= bus.i_vsync;
      hs_out_reg  <= bus.i_hsync;
      de_out_reg  <= bus.i_de;
      tap0_reg    <= bus.i_data;
      ptr_out_reg <= wr_ptr_reg;
      vld_reg     <= vld_next;
      col_out_reg <= in_line ? col_reg[AW-1:0] : AW'(HACT - 1);
    end
  end

  // Line memories: registered read-first access, contents never reset.
  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_mem
      logic [DW-1:0] mem [HACT];
      logic [DW-1:0] rd_data_reg;

      always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_reg == PW'(gi)))
          mem[addr] <= bus.i_data;
        rd_data_reg <= mem[addr];
      end

      assign rd_bus[gi] = rd_data_reg;
    end
  endgenerate

  assign bus.o_taps[0 +: DW] = vld_reg[0] ? tap0_reg : '0;

  // Tap k reads the memory written k lines ago: (wr_ptr - k) mod M.
  generate
    for (genvar gi = 1; gi < NLINES; gi++) begin : g_tap
      logic [PW:0] sel_sum;

      always_comb begin
        sel_sum = {1'b0, ptr_out_reg} + (PW + 1)'(M - gi);
        if (sel_sum >= (PW + 1)'(M))
          sel_sum = sel_sum - (PW + 1)'(M);
      end

      assign bus.o_taps[gi*DW +: DW] = vld_reg[gi] ? rd_bus[sel_sum[PW-1:0]] : '0;
    end
  endgenerate

  assign bus.o_vsync   = vs_out_reg;
  assign bus.o_hsync   = hs_out_reg;
  assign bus.o_de      = de_out_reg;
  assign bus.o_tap_vld = vld_reg;
  assign bus.o_col     = col_out_reg;
  assign bus.o_ovf     = ovf_reg;
endmodule

// File: tb/tb_line_buf_ring.sv
// Directed bench for line_buf_ring (NLINES=3, HACT=4, DW=30, pixel = row*16+col):
// each vector's outputs are checked one clock after its inputs are applied.
module tb_line_buf_ring;
  localparam int DW     = 30;
  localparam int HACT   = 4;
  localparam int NLINES = 3;

  typedef struct {
    logic          rst;
    logic          vs;
    logic          hs;
    logic          de;
    logic [DW-1:0] data;
    logic [2:0]    vld;
    logic [DW-1:0] t0;
    logic [DW-1:0] t1;
    logic [DW-1:0] t2;
    logic [1:0]    col;
    logic          ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_vec  = 0;
  vec_t tbl [$];

  line_buf_ring_if #(.DW(DW), .HACT(HACT), .NLINES(NLINES)) bus ();

  line_buf_ring #(.DW(DW), .HACT(HACT), .NLINES(NLINES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, input int vs, input int hs, input int de,
                              input int data, input int vld, input int t0,
                              input int t1, input int t2, input int col, input int ovf);
    vec_t v;
    v.rst  = 1'(r);
    v.vs   = 1'(vs);
    v.hs   = 1'(hs);
    v.de   = 1'(de);
    v.data = DW'(data);
    v.vld  = 3'(vld);
    v.t0   = DW'(t0);
    v.t1   = DW'(t1);
    v.t2   = DW'(t2);
    v.col  = 2'(col);
    v.ovf  = 1'(ovf);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [2:0]           exp_tim;
    logic [NLINES*DW-1:0] exp_taps;
    rst         = v.rst;
    bus.i_vsync = v.vs;
    bus.i_hsync = v.hs;
    bus.i_de    = v.de;
    bus.i_data  = v.data;
    @(posedge clk);
    #1;
    exp_tim  = v.rst ? 3'b000 : {v.vs, v.hs, v.de};
    exp_taps = {v.t2, v.t1, v.t0};
    n_chk++;
    if ({bus.o_vsync, bus.o_hsync, bus.o_de} !== exp_tim || bus.o_tap_vld !== v.vld ||
        bus.o_taps !== exp_taps || bus.o_col !== v.col || bus.o_ovf !== v.ovf) begin
      n_fail++;
      $display("FAIL vec %0d: got vs/hs/de=%b vld=%b taps=%h col=%0d ovf=%b, expected vs/hs/de=%b vld=%b taps=%h col=%0d ovf=%b",
               n_vec, {bus.o_vsync, bus.o_hsync, bus.o_de}, bus.o_tap_vld, bus.o_taps,
               bus.o_col, bus.o_ovf, exp_tim, v.vld, exp_taps, v.col, v.ovf);
    end else begin
      $display("vec %0d ok: rst=%b vs/hs/de=%b vld=%b taps=%h col=%0d ovf=%b",
               n_vec, v.rst, exp_tim, v.vld, exp_taps, v.col, v.ovf);
    end
    n_vec++;
  endtask

  task automatic add(input int r, input int vs, input int hs, input int de, input int data,
                     input int vld, input int t0, input int t1, input int t2,
                     input int col, input int ovf);
    tbl.push_back(mk(r, vs, hs, de, data, vld, t0, t1, t2, col, ovf));
  endtask

  // A full line of n pixels base+c with tap1/tap2 expected as t1b+c / t2b+c.
  task automatic row(input int base, input int n, input int vld, input int t1b,
                     input int t2b, input int ovf);
    for (int c = 0; c < n; c++)
      add(0, 0, 0, 1, base + c, vld, base + c, (vld & 2) ? t1b + c : 0,
          (vld & 4) ? t2b + c : 0, c, ovf);
  endtask

  // Two idle cycles: the first still shows the end-of-line column.
  task automatic gap(input int col_first, input int ovf);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, col_first, ovf);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ovf);
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_vsync = 1'b0;
    bus.i_hsync = 1'b0;
    bus.i_de    = 1'b0;
    bus.i_data  = '0;

    // Reset held: every output is zero.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Reset dropped into the middle of a line abandons it.
    for (int c = 0; c < 2; c++)
      apply(mk(0, 0, 0, 1, 'hE0 + c, 3'b001, 'hE0 + c, 0, 0, c, 0));
    for (int c = 2; c < 4; c++)
      apply(mk(1, 0, 0, 1, 'hE0 + c, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 4; c++)
      apply(mk(0, 0, 0, 1, 'hF0 + c, 3'b001, 'hF0 + c, 0, 0, c, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Next line must see the post-reset line stored from column 0 of memory 0.
    for (int c = 0; c < 4; c++)
      apply(mk(0, 0, 0, 1, 'hC0 + c, 3'b011, 'hC0 + c, 'hF0 + c, 0, c, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Frame start, hsync pass-through, then rows 0..2 filling the ring.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    row('h00, 4, 3'b001, 0, 0, 0);         gap(3, 0);
    row('h10, 4, 3'b011, 'h00, 0, 0);      gap(3, 0);
    row('h20, 4, 3'b111, 'h10, 'h00, 0);
    // vsync after row 2 empties the ring.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row('h30, 4, 3'b001, 0, 0, 0);         gap(3, 0);
    // Overlong row: pixels 5 and 6 are not stored and raise ovf.
    row('h40, 4, 3'b011, 'h30, 0, 0);
    add(0, 0, 0, 1, 'h44, 3'b001, 'h44, 0, 0, 3, 1);
    add(0, 0, 0, 1, 'h45, 3'b001, 'h45, 0, 0, 3, 1);
    gap(3, 1);
    row('h50, 4, 3'b111, 'h40, 'h30, 1);   gap(3, 1);
    // Short row then a full row that sees partly stale data on tap1.
    row('h60, 2, 3'b111, 'h50, 'h40, 1);   gap(2, 1);
    add(0, 0, 0, 1, 'h70, 3'b111, 'h70, 'h60, 'h50, 0, 1);
    add(0, 0, 0, 1, 'h71, 3'b111, 'h71, 'h61, 'h51, 1, 1);
    add(0, 0, 0, 1, 'h72, 3'b111, 'h72, 'h42, 'h52, 2, 1);
    add(0, 0, 0, 1, 'h73, 3'b111, 'h73, 'h43, 'h53, 3, 1);
    gap(3, 1);
    add(0, 0, 0, 1, 'h80, 3'b111, 'h80, 'h70, 'h60, 0, 1);
    add(0, 0, 0, 1, 'h81, 3'b111, 'h81, 'h71, 'h61, 1, 1);
    add(0, 0, 0, 1, 'h82, 3'b111, 'h82, 'h72, 'h42, 2, 1);
    add(0, 0, 0, 1, 'h83, 3'b111, 'h83, 'h73, 'h43, 3, 1);
    // vsync coincident with the de fall: ring restarts empty at pointer 0.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row('h90, 4, 3'b001, 0, 0, 0);         gap(3, 0);
    row('hA0, 4, 3'b011, 'h90, 0, 0);      gap(3, 0);

    foreach (tbl[i])
      apply(tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/line_buf_ring.md
LINE_BUF_RING -- requirements
Module: line_buf_ring

Interface
REQ-001 The block SHALL take parameter DW, default 30, as the pixel width in bits (packed {R,G,B}).
REQ-002 The block SHALL take parameter HACT, default 10, as the active pixels per line; legal values are 2 or more.
REQ-003 The block SHALL take parameter NLINES, default 3, as the number of vertical taps; legal values are 2..8.
REQ-004 The block SHALL derive localparams M = NLINES-1 (the number of internal line memories) and AW = $clog2(HACT).
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have ports i_vsync, i_hsync and i_de, each an input of width 1: the input timing signals.
REQ-008 The block SHALL have port i_data, input, width DW: the input pixel, valid when i_de=1.
REQ-009 The block SHALL have ports o_vsync, o_hsync and o_de, each an output of width 1: the input timing delayed 1 clk.
REQ-010 The block SHALL have port o_taps, output, width NLINES*DW: slice k ([k*DW +: DW]) carries the pixel k lines above the current line, same column.
REQ-011 The block SHALL have port o_tap_vld, output, width NLINES: bit k=1 means slice k holds real data.
REQ-012 The block SHALL have port o_col, output, width AW: the column index of the pixel currently presented.
REQ-013 The block SHALL have port o_ovf, output, width 1: a sticky flag meaning a line exceeded HACT pixels in the current frame.

Function
REQ-014 The block SHALL hold M internal line memories of HACT x DW each, read-first: reading and writing the same address in one cycle returns the old data.
REQ-015 Column counter col SHALL increment on each i_de=1 cycle while col < HACT, and SHALL hold once it reaches HACT.
REQ-016 The end of a line SHALL be the falling edge of i_de (i_de registered = 1 and i_de = 0).
- At end of line: col <= 0, wr_ptr <= (wr_ptr+1) mod M, fill <= min(fill+1, M).
REQ-017 When i_de=1 and col < HACT, i_data SHALL be written to memory wr_ptr at address col.
- In the same cycle, every memory SHALL be read at address col.
REQ-018 Memory (wr_ptr-k) mod M SHALL supply tap k, for k = 1..M.
REQ-019 Output timing SHALL be a 1-clk pipeline.
- o_de, o_hsync and o_vsync are the inputs delayed 1 clk.
- Tap 0 is i_data delayed 1 clk.
- Taps 1..M are the memory read data.
- o_col is col delayed 1 clk.
REQ-020 Tap validity SHALL be defined as follows.
- o_tap_vld[0] = o_de.
- o_tap_vld[k] = o_de & (fill >= k) & (col < HACT), with fill and col sampled at the read cycle.
- A slice whose vld bit = 0 SHALL output all zeros.
REQ-021 On an overlong line, pixels with col >= HACT SHALL NOT be written.
- Those pixels still appear on tap 0 with o_col = HACT-1.
- They set o_ovf = 1.
REQ-022 While i_vsync=1, the block SHALL force col <= 0, wr_ptr <= 0, fill <= 0 and o_ovf <= 0.
- vsync takes priority over a simultaneous i_de fall and over writes.
- Memory contents are not cleared.
REQ-023 A short line (fewer than HACT pixels) SHALL still advance wr_ptr.
- Its unwritten columns return stale data, with vld per REQ-020.
REQ-024 i_hsync SHALL affect nothing other than its delayed output.

Reset
REQ-025 While rst=1, at each clk edge all outputs SHALL be driven to 0, with col, wr_ptr, fill and the internal i_de delay register all set to 0.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 A reset asserted mid-line SHALL abandon that line; the first i_de after rst drops SHALL write column 0 of memory 0.

Verification (NLINES=3, HACT=4, DW=30, pixel = row*16+col)
REQ-028 Scenario: rst for 2 clk mid-line -> cycle after the rst edge, all outputs 0; the next line writes memory 0 at column 0.
REQ-029 Scenario: vsync, then rows 0..2 with 4 pixels each, 2-clk gaps.
- Row 0: o_tap_vld = 001.
- Row 1: vld = 011, tap1 = 0x00..0x03.
- Row 2: vld = 111, tap1 = 0x10..0x13, tap2 = 0x00..0x03.
- In every case, output appears 1 clk after the input.
REQ-030 Scenario: vsync pulse after row 2, then a new row -> vld = 001, o_ovf = 0; taps 1 and 2 are zero.
REQ-031 Scenario: a row of 6 pixels -> o_ovf = 1 from the 5th pixel on.
- On the next row, tap1 = the first 4 pixels only.
- The o_col sequence is 0,1,2,3,3,3.
REQ-032 Scenario: a 2-pixel row followed by a full row -> tap1 cols 0-1 = new data, cols 2-3 = previous contents; wr_ptr advanced.
REQ-033 Scenario: i_vsync rises in the same cycle as an i_de fall -> wr_ptr = 0, fill = 0; no extra advance.
